systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Feeds activation vectors into the west edge of the systolic PE array. Accepts one ROWS-wide vector per
//  valid/ready beat, and skews it so that row r sees its element r+1 cycles after acceptance (diagonal wavefront).
//  Drives data_a_i and acc_en of the first PE column per row, then signals completion once a tile has fully drained.
// PARAMETERS
//  DATA_WIDTH  16  width of one signed activation element
//  ROWS        4   number of array rows (lanes); >= 1
//  MAX_BEATS   64  max vectors per tile; beat MAX_BEATS is treated as last even without in_last
// PORTS
//  clk          in   1                clock, all logic rising-edge
//  rst          in   1                synchronous reset, active-high
//  in_valid     in   1                upstream vector valid
//  in_ready     out  1                feeder can accept a beat this cycle
//  in_data      in   ROWS*DATA_WIDTH  signed elements; lane r = in_data[r*DATA_WIDTH +: DATA_WIDTH]
//  in_last      in   1                qualifies the final beat of a tile
//  data_a_o     out  ROWS*DATA_WIDTH  skewed lane data to PE column 0 (lane r -> row r data_a_i)
//  acc_en_o     out  ROWS             per-row accumulate enable, aligned with data_a_o lane r
//  tile_done_o  out  1                one-cycle pulse, coincident with final valid beat on lane ROWS-1
//  beat_cnt_o   out  $clog2(MAX_BEATS+1)  beats accepted in the current tile
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state IDLE, every delay stage data=0 and valid=0, data_a_o=0, acc_en_o=0,
//    tile_done_o=0, beat_cnt_o=0, in_ready=0 while rst is high. Reset mid-tile discards all in-flight beats; no done pulse.
//  - Handshake: beat accepted at an edge where in_valid && in_ready. in_ready = !rst && (state != FLUSH).
//    in_data/in_last sampled only on acceptance; in_valid may drop at any time (bubble).
//  - Array path is never stalled: every delay stage shifts every cycle. A non-accepting cycle injects data=0, valid=0.
//  - Latency: beat accepted at edge t -> lane r shows data and acc_en_o[r]=1 during cycle t+1+r (registered stage 0 + r stages).
//  - Bubbles propagate: a gap of g cycles upstream gives g-cycle acc_en_o=0 gaps on every lane, each shifted by r.
//  - data_a_o lane is forced to 0 whenever that lane's acc_en_o is 0 (PEs never see stale data).
//  - FSM:
//      IDLE   : accept -> STREAM (or FLUSH if beat is last); beat_cnt <= 1.
//      STREAM : each accept increments beat_cnt; accept of last beat -> FLUSH.
//      FLUSH  : no acceptance; flush_cnt counts ROWS cycles from 0. In cycle ROWS-1 of FLUSH
//               (= last beat on lane ROWS-1) tile_done_o=1, and the FSM returns to IDLE at the following edge with beat_cnt <= 0.
//    "Last beat" = in_last || (beat_cnt == MAX_BEATS-1 at acceptance). in_last while !in_valid is ignored.
//  - Single-beat tile (IDLE accept with in_last): FLUSH entered directly; done pulse ROWS cycles after accept.
//  - ROWS=1: no skew stages beyond stage 0; FLUSH lasts 1 cycle; done coincides with lane 0's final beat.
//  - Back-to-back tiles: in_ready returns high in the cycle after tile_done_o; min gap between tiles is ROWS cycles.
//  - Arithmetic: none on data; beat_cnt never exceeds MAX_BEATS (saturation is impossible by the forced-last rule).
// STRUCTURE
//  - systolic_pkg: feeder_state_e {IDLE, STREAM, FLUSH}; DATA_WIDTH default constant shared with pe/mac.
//  - Sub-module skew_delay_line #(WIDTH, DEPTH): DEPTH-stage shift register of {valid, data}, sync reset to 0;
//    instantiated per lane with DEPTH=r (generate loop; DEPTH=0 is a pass-through).
//  - Top holds stage-0 input register, FSM, beat_cnt, flush_cnt, done register.
// TESTING  (ROWS=4, DATA_WIDTH=16, MAX_BEATS=64 unless noted)
//  1 Single beat {4,3,2,1} (lane0=1) with in_last at edge 0 -> lane r=r+1 in cycle 1+r; acc_en_o one-hot walks 0001..1000;
//    tile_done_o high only in cycle 4; in_ready low cycles 1-4, high cycle 5.
//  2 8 contiguous beats, lane values = beat index k -> row r shows k in cycle k+1+r; acc_en_o[3] high cycles 4-11; done at cycle 11.
//  3 Beats at edges 0,1,4 (bubble 2-3), last at 4 -> acc_en_o[2] high 3,4,7, low 5,6; data_a_o lane2 = 0 in 5,6.
//  4 in_last never asserted, 64 beats -> beat 64 forced last; in_ready low after it; done 4 cycles after; beat_cnt_o peaks at 64.
//  5 rst=1 in cycle 6 of scenario 2 -> next cycle all acc_en_o=0, data_a_o=0, beat_cnt_o=0, no tile_done_o; new tile then starts cleanly.
//  6 Back-to-back tiles (in_valid held high) -> second tile's first accept the cycle after done; no beat lost or duplicated (scoreboard).

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array blocks (feeder, PE, MAC).
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } feeder_state_e;

  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register of {valid, data}; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_shift
      logic [DEPTH-1:0] valid_q;
      logic [WIDTH-1:0] data_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
          valid_q[0] <= in_valid;
          data_q[0]  <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
          end
        end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// West-edge activation feeder: registers each accepted vector, then delays lane r by r
// extra cycles to form the diagonal wavefront, and pulses tile_done_o when a tile has drained.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ROWS       = 4,
  parameter int MAX_BEATS  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]      in_data,
  input  logic                            in_last,
  output logic [ROWS*DATA_WIDTH-1:0]      data_a_o,
  output logic [ROWS-1:0]                 acc_en_o,
  output logic                            tile_done_o,
  output logic [$clog2(MAX_BEATS+1)-1:0]  beat_cnt_o
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;

  feeder_state_e state, state_next;
  logic [CW-1:0] beat_cnt, beat_cnt_next;
  logic [FW-1:0] flush_cnt, flush_cnt_next;
  logic accept;
  logic is_last;
  logic done_next;
  logic done_q;
  logic valid_s0;
  logic [ROWS*DATA_WIDTH-1:0] data_s0;

  assign accept  = in_valid && in_ready;
  assign is_last = in_last || (beat_cnt == CW'(MAX_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_cnt_next;
      flush_cnt <= flush_cnt_next;
      done_q    <= done_next;
    end
  end

  // FLUSH lasts exactly ROWS cycles so its final cycle lines up with the last beat on lane ROWS-1.
  always_comb begin
    state_next     = state;
    beat_cnt_next  = beat_cnt;
    flush_cnt_next = flush_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          beat_cnt_next  = CW'(1);
          flush_cnt_next = '0;
          state_next     = is_last ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          beat_cnt_next = beat_cnt + CW'(1);
          if (is_last) begin
            state_next     = FLUSH;
            flush_cnt_next = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == FW'(ROWS - 1)) begin
          state_next     = IDLE;
          beat_cnt_next  = '0;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt + FW'(1);
        end
      end
      default: begin
        state_next     = IDLE;
        beat_cnt_next  = '0;
        flush_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state != FLUSH);
    done_next = (state_next == FLUSH) && (flush_cnt_next == FW'(ROWS - 1));
  end

  // Idle cycles inject zero data so downstream stages never carry stale values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s0 <= 1'b0;
      data_s0  <= '0;
    end else begin
      valid_s0 <= accept;
      data_s0  <= accept ? in_data : '0;
    end
  end

  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_lane
      logic                  lane_valid;
      logic [DATA_WIDTH-1:0] lane_data;

      skew_delay_line #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (r)
      ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid_s0),
        .in_data   (data_s0[r*DATA_WIDTH +: DATA_WIDTH]),
        .out_valid (lane_valid),
        .out_data  (lane_data)
      );

      assign acc_en_o[r] = lane_valid;
      assign data_a_o[r*DATA_WIDTH +: DATA_WIDTH] = lane_valid ? lane_data : '0;
    end
  endgenerate

  assign tile_done_o = done_q;
  assign beat_cnt_o  = beat_cnt;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-scenario plans of driven beats and hand-derived
// cycle expectations, checked with immediate assertions every cycle.
module tb_systolic_skew_feeder;

  localparam int DW   = 16;
  localparam int ROWS = 4;
  localparam int MAXB = 64;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int N    = 80;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic                 in_last;
  logic [ROWS*DW-1:0]   data_a_o;
  logic [ROWS-1:0]      acc_en_o;
  logic                 tile_done_o;
  logic [CW-1:0]        beat_cnt_o;

  int checks   = 0;
  int failures = 0;

  bit                 drv_valid [N];
  bit                 drv_last  [N];
  bit                 drv_rst   [N];
  bit                 acc_at    [N];
  logic [ROWS*DW-1:0] drv_data  [N];
  bit                 exp_ready [N];
  bit                 exp_done  [N];
  int                 exp_cnt   [N];
  int                 rst_edge;
  int                 lane3_beats;

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .DATA_WIDTH (DW),
    .ROWS       (ROWS),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .data_a_o    (data_a_o),
    .acc_en_o    (acc_en_o),
    .tile_done_o (tile_done_o),
    .beat_cnt_o  (beat_cnt_o)
  );

  task automatic check_val(input string tag, input int c, input logic [63:0] observed,
                           input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, observed, expected);
    end
  endtask

  task automatic clear_plan();
    for (int e = 0; e < N; e++) begin
      drv_valid[e] = 1'b0;
      drv_last[e]  = 1'b0;
      drv_rst[e]   = 1'b0;
      acc_at[e]    = 1'b0;
      drv_data[e]  = '0;
      exp_ready[e] = 1'b1;
      exp_done[e]  = 1'b0;
      exp_cnt[e]   = 0;
    end
    rst_edge = -1;
  endtask

  // After a last beat accepted at edge le: ROWS cycles of FLUSH, done in the final one.
  task automatic expect_flush(input int le, input int total);
    for (int c = le + 1; c <= le + ROWS; c++) begin
      exp_ready[c] = 1'b0;
      exp_cnt[c]   = total;
    end
    exp_done[le + ROWS] = 1'b1;
  endtask

  task automatic applyStimulus(input int e);
    rst      = drv_rst[e];
    in_valid = drv_valid[e];
    in_last  = drv_last[e];
    in_data  = drv_data[e];
  endtask

  task automatic checkOutput(input string name, input int c);
    logic [ROWS-1:0]    exp_acc;
    logic [ROWS*DW-1:0] exp_data;
    int a;
    bit v;
    exp_acc  = '0;
    exp_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      a = c - 1 - r;
      v = (a >= 0) && acc_at[a] && !((rst_edge > a) && (rst_edge <= c - 1));
      exp_acc[r] = v;
      if (v) exp_data[r*DW +: DW] = drv_data[a][r*DW +: DW];
    end
    if (acc_en_o[3] === 1'b1) lane3_beats++;
    check_val({name, ".acc_en"}, c, 64'(acc_en_o), 64'(exp_acc));
    check_val({name, ".data_a"}, c, 64'(data_a_o), 64'(exp_data));
    check_val({name, ".done"}, c, 64'(tile_done_o), 64'(exp_done[c]));
    check_val({name, ".ready"}, c, 64'(in_ready), 64'(exp_ready[c]));
    check_val({name, ".beat_cnt"}, c, 64'(beat_cnt_o), 64'(exp_cnt[c]));
  endtask

  // Cycle c is the interval between edge c-1 and edge c; inputs for edge c are driven inside it.
  task automatic run_plan(input string name, input int n);
    applyStimulus(0);
    #1;
    checkOutput(name, 0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(c);
      #1;
      checkOutput(name, c);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.acc_en", 0, 64'(acc_en_o), 64'd0);
    check_val("reset.data_a", 0, 64'(data_a_o), 64'd0);
    check_val("reset.done", 0, 64'(tile_done_o), 64'd0);
    check_val("reset.ready", 0, 64'(in_ready), 64'd0);
    check_val("reset.beat_cnt", 0, 64'(beat_cnt_o), 64'd0);

    // Single last beat {4,3,2,1}
    clear_plan();
    drv_valid[0] = 1'b1;
    drv_last[0]  = 1'b1;
    acc_at[0]    = 1'b1;
    drv_data[0]  = {16'd4, 16'd3, 16'd2, 16'd1};
    expect_flush(0, 1);
    run_plan("single", 5);

    // Eight contiguous beats, every lane carries the beat index
    clear_plan();
    for (int k = 0; k < 8; k++) begin
      drv_valid[k] = 1'b1;
      acc_at[k]    = 1'b1;
      drv_data[k]  = {4{16'(k)}};
      if (k < 7) exp_cnt[k+1] = k + 1;
    end
    drv_last[7] = 1'b1;
    expect_flush(7, 8);
    run_plan("burst8", 12);

    // Beats at edges 0,1,4 with a two-cycle bubble
    clear_plan();
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || k == 1 || k == 4) begin
        drv_valid[k] = 1'b1;
        acc_at[k]    = 1'b1;
        for (int r = 0; r < ROWS; r++) drv_data[k][r*DW +: DW] = 16'((k + 1) * 16 + r);
      end
    end
    drv_last[4] = 1'b1;
    exp_cnt[1] = 1;
    exp_cnt[2] = 2;
    exp_cnt[3] = 2;
    exp_cnt[4] = 2;
    expect_flush(4, 3);
    run_plan("bubble", 9);

    // No in_last: beat 64 is forced last, valid kept high through FLUSH
    clear_plan();
    for (int k = 0; k < 68; k++) begin
      drv_valid[k] = 1'b1;
      for (int r = 0; r < ROWS; r++) drv_data[k][r*DW +: DW] = 16'(k * 4 + r);
      if (k < 64) acc_at[k] = 1'b1;
      if (k >= 1 && k <= 63) exp_cnt[k] = k;
    end
    expect_flush(63, 64);
    run_plan("maxbeats", 68);

    // Reset in cycle 6 of an 8-beat tile, then the still-valid beat at edge 7 opens a new tile
    clear_plan();
    for (int k = 0; k < 8; k++) begin
      drv_valid[k] = 1'b1;
      drv_data[k]  = {4{16'(k + 100)}};
      if (k <= 5 || k == 7) acc_at[k] = 1'b1;
      if (k >= 1 && k <= 6) exp_cnt[k] = k;
    end
    drv_last[7]  = 1'b1;
    drv_rst[6]   = 1'b1;
    rst_edge     = 6;
    exp_ready[6] = 1'b0;
    expect_flush(7, 1);
    run_plan("midreset", 12);

    // Back-to-back tiles with in_valid held high; distinct data on every edge
    clear_plan();
    for (int k = 0; k < 14; k++) begin
      drv_valid[k] = 1'b1;
      for (int r = 0; r < ROWS; r++) drv_data[k][r*DW +: DW] = 16'(16'h1000 + k * 16 + r);
    end
    drv_last[2] = 1'b1;
    drv_last[9] = 1'b1;
    acc_at[0] = 1'b1;
    acc_at[1] = 1'b1;
    acc_at[2] = 1'b1;
    acc_at[7] = 1'b1;
    acc_at[8] = 1'b1;
    acc_at[9] = 1'b1;
    exp_cnt[1] = 1;
    exp_cnt[2] = 2;
    expect_flush(2, 3);
    exp_cnt[8] = 1;
    exp_cnt[9] = 2;
    expect_flush(9, 3);
    lane3_beats = 0;
    run_plan("b2b", 14);
    check_val("b2b.lane3_beats", 14, 64'(lane3_beats), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
